sha256_block_sequencer: RTL and testbench
=========================================

Name: sha256_block_sequencer

Overview:
- Front-end controller for the SHA-256 compression core.
- Accepts a message as a stream of 32-bit big-endian words and assembles them into 512-bit blocks.
- Applies the FIPS 180-4 padding: 0x80 marker, zero fill and a 64-bit bit-length.
- Issues one block at a time to the core over a valid/ready handshake, then waits for the core's completion pulse before issuing the next block.

Parameters:
- LEN_W, 64, width of the internal message bit-length counter; zero-extended to 64 bits when written into words 14/15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  message word; the first message byte is in [31:24].
- in_bytes  in  3  number of valid bytes in in_data (0..4), left-justified. Must be 4 unless in_last=1. Value 0 is legal only with in_last=1 (empty or exact-word end).
- in_last  in  1  marks the final word of the message.
- in_valid  in  1  input word is valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- blk_data  out  512  block to the core; word 0 is in [511:480], word 15 in [31:0].
- blk_first  out  1  this is the first block of the message (core loads the initial H values).
- blk_last  out  1  this is the final block of the message.
- blk_valid  out  1  block is presented.
- blk_ready  in  1  core accepts the block.
- core_done  in  1  one-cycle pulse from the core when compression of the accepted block finishes.
- msg_done  out  1  one-cycle pulse when the core finishes the last block.
- busy  out  1  high from the first accepted word until msg_done.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to FILL; word index 0; length counter 0; first flag 1; pending-pad flags cleared; buffer cleared.
  - Outputs: in_ready=0 during the reset cycle; blk_valid=0, blk_first=0, blk_last=0, msg_done=0, busy=0; blk_data=0.
  - Reset mid-message discards all state; a blk_valid in progress drops the next cycle.
- States: FILL, PAD, ISSUE, WAIT.
- FILL:
  - in_ready=1; one word accepted per in_valid&in_ready.
  - Word stored at buffer[idx]; length += 8*in_bytes (mod 2^LEN_W).
  - Non-last word at idx 15 -> ISSUE with last=0, idx <- 0. Otherwise idx++.
  - in_last with in_bytes<4: 0x80 is placed in the byte right after the valid bytes, lower bytes are zeroed, and the marker is flagged as done -> PAD.
  - in_last with in_bytes=4 and idx<15: 0x80000000 is written at idx+1 -> PAD.
  - in_last with in_bytes=4 at idx 15: marker deferred (need_marker=1) -> ISSUE.
  - in_bytes=0 with in_last: 0x80000000 is written at idx -> PAD.
- PAD (1 cycle):
  - Words after the marker are zeroed.
  - If the marker word index is ≤13: words 14/15 <- 64-bit length (MSW in 14), last=1.
  - Else: last=0, need_len=1.
  - Either way -> ISSUE.
- Continuation block (entered from WAIT when need_marker or need_len is set):
  - Buffer zeroed; word 0 = 0x80000000 if need_marker.
  - Words 14/15 <- length; last=1; both flags cleared -> ISSUE.
- ISSUE:
  - blk_valid=1; blk_data/blk_first/blk_last are registered and stable until blk_valid&blk_ready.
  - in_ready=0 throughout.
  - On the handshake: blk_valid=0, first flag <- 0 -> WAIT.
  - core_done in ISSUE is ignored.
- WAIT:
  - in_ready=0.
  - On core_done:
    - If the issued block had last=1: msg_done=1 for one cycle, first flag <- 1, length <- 0, idx <- 0 -> FILL.
    - Else if need_marker or need_len: build the continuation block (next cycle) -> ISSUE.
    - Else -> FILL.
- Latency:
  - Last input word to blk_valid: 2 cycles (PAD path), or 1 cycle for a full 16-word non-last block.
  - core_done to msg_done: 1 cycle, registered.
- Simultaneous events: rst has priority over everything; in_valid while in_ready=0 is held off by the source (AXI-style).
- Length wraps modulo 2^LEN_W; no error flag.

Test Plan:
- Empty message (in_bytes=0, in_last=1):
  - One block: word0=0x80000000, words1..15=0, first=last=1.
  - core_done -> msg_done pulse next cycle, busy falls.
- "abc" (in_data=0x61626300, in_bytes=3, last):
  - word0=0x61626380, word15=0x00000018, other words 0, first=last=1.
- 55 bytes (13 full words + 0xAABBCC00 with bytes=3, last):
  - Single block; word13=0xAABBCC80, word14=0, word15=0x000001B8.
- 56 bytes (14 full words, last has bytes=4):
  - Block A: word14=0x80000000, word15=0, first=1, last=0.
  - After core_done, block B: all zero except word15=0x000001C0, first=0, last=1.
- 64 bytes (16 full words, last at idx 15):
  - Block A: data only, last=0.
  - Block B: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure and reset:
  - Hold blk_ready=0 for 5 cycles with core_done pulsed: blk_data stays stable, no state advance, in_ready=0.
  - Assert rst during WAIT: next cycle blk_valid=0, busy=0; a fresh "abc" then yields the same block as the "abc" scenario.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// SHA-256 front end: packs 32-bit message words into 512-bit blocks,
// applies the 0x80 / zero / bit-length padding and feeds the core one block at a time.
module sha256_block_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    input  logic         core_done,
    output logic         msg_done,
    output logic         busy
);

    typedef enum logic [1:0] {FILL, PAD, ISSUE, WAIT} state_t;

    state_t             state_q;
    logic [3:0]         idx_q;
    logic [3:0]         mark_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [63:0]        len64;
    logic               first_q;
    logic               need_marker_q;
    logic               need_len_q;
    logic [31:0]        buf_q [16];
    logic [31:0]        mark_word_d;
    logic               blk_valid_q;
    logic               blk_first_q;
    logic               blk_last_q;
    logic               msg_done_q;
    logic               busy_q;

    assign in_ready  = (state_q == FILL) && !rst;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign msg_done  = msg_done_q;
    assign busy      = busy_q;

    assign len_d = len_q + LEN_W'({in_bytes, 3'b000});
    assign len64 = 64'(len_q);

    // Final partial word: keep the valid bytes, drop in the 0x80 marker, zero the rest.
    always_comb begin
        mark_word_d = 32'h8000_0000;
        case (in_bytes)
            3'd1:    mark_word_d = {in_data[31:24], 8'h80, 16'h0000};
            3'd2:    mark_word_d = {in_data[31:16], 8'h80, 8'h00};
            3'd3:    mark_word_d = {in_data[31:8], 8'h80};
            default: mark_word_d = 32'h8000_0000;
        endcase
    end

    // Present the buffer as the block, word 0 in the top bits.
    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 16; i++) begin
            blk_data[511-32*i -: 32] = buf_q[i];
        end
    end

    // Main sequencer: fill, pad, issue, wait for the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= '0;
            mark_q        <= '0;
            len_q         <= '0;
            first_q       <= 1'b1;
            need_marker_q <= 1'b0;
            need_len_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b0;
            blk_last_q    <= 1'b0;
            msg_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            msg_done_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (in_valid) begin
                        busy_q <= 1'b1;
                        len_q  <= len_d;
                        if (in_last && in_bytes < 3'd4) begin
                            buf_q[idx_q] <= mark_word_d;
                            mark_q       <= idx_q;
                            state_q      <= PAD;
                        end else if (in_last && idx_q != 4'd15) begin
                            buf_q[idx_q]        <= in_data;
                            buf_q[idx_q + 4'd1] <= 32'h8000_0000;
                            mark_q              <= idx_q + 4'd1;
                            state_q             <= PAD;
                        end else begin
                            buf_q[idx_q] <= in_data;
                            if (idx_q == 4'd15) begin
                                need_marker_q <= in_last;
                                blk_valid_q   <= 1'b1;
                                blk_first_q   <= first_q;
                                blk_last_q    <= 1'b0;
                                idx_q         <= '0;
                                state_q       <= ISSUE;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < 16; i++) begin
                        if (4'(i) > mark_q) buf_q[i] <= '0;
                    end
                    if (mark_q <= 4'd13) begin
                        buf_q[14]  <= len64[63:32];
                        buf_q[15]  <= len64[31:0];
                        blk_last_q <= 1'b1;
                    end else begin
                        need_len_q <= 1'b1;
                        blk_last_q <= 1'b0;
                    end
                    blk_valid_q <= 1'b1;
                    blk_first_q <= first_q;
                    idx_q       <= '0;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        if (blk_last_q) begin
                            msg_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            first_q    <= 1'b1;
                            len_q      <= '0;
                            idx_q      <= '0;
                            state_q    <= FILL;
                        end else if (need_marker_q || need_len_q) begin
                            for (int i = 0; i < 16; i++) begin
                                buf_q[i] <= '0;
                            end
                            buf_q[0]      <= need_marker_q ? 32'h8000_0000 : 32'h0;
                            buf_q[14]     <= len64[63:32];
                            buf_q[15]     <= len64[31:0];
                            need_marker_q <= 1'b0;
                            need_len_q    <= 1'b0;
                            blk_valid_q   <= 1'b1;
                            blk_first_q   <= first_q;
                            blk_last_q    <= 1'b1;
                            state_q       <= ISSUE;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: padding cases,
// multi-block messages, backpressure and mid-message reset.
module tb_sha256_block_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  in_data = '0;
    logic [2:0]   in_bytes = '0;
    logic         in_last = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         core_done = 1'b0;
    logic         msg_done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [31:0]  ew [16];
    logic [511:0] snap;

    sha256_block_sequencer #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .core_done(core_done), .msg_done(msg_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
        in_data  = d;
        in_bytes = b;
        in_last  = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = '0;
    endtask

    function automatic logic [511:0] pack_ew();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = ew[i];
        return r;
    endfunction

    task automatic wait_blk(input string tag);
        int n;
        n = 0;
        while (!blk_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, blk_valid, 1'b1);
    endtask

    task automatic check_blk(input string tag, input logic f, input logic l);
        chk({tag, "_data"}, blk_data, pack_ew());
        chk({tag, "_first"}, blk_first, f);
        chk({tag, "_last"}, blk_last, l);
        chk({tag, "_inrdy"}, in_ready, 1'b0);
    endtask

    task automatic accept(input string tag);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        chk({tag, "_drop"}, blk_valid, 1'b0);
    endtask

    task automatic done(input string tag, input logic exp_msg);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk({tag, "_msg"}, msg_done, exp_msg);
        if (exp_msg) begin
            chk({tag, "_busy"}, busy, 1'b0);
            tick();
            chk({tag, "_msg_pulse"}, msg_done, 1'b0);
            chk({tag, "_fill"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_inrdy", in_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_inrdy_after", in_ready, 1'b1);
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_msg", msg_done, 1'b0);
        chk("rst_data", blk_data, 512'h0);
        chk("rst_first", blk_first, 1'b0);
        chk("rst_last", blk_last, 1'b0);

        // Empty message
        send(32'h0, 3'd0, 1'b1);
        chk("empty_busy", busy, 1'b1);
        wait_blk("empty");
        clr_ew();
        ew[0] = 32'h8000_0000;
        check_blk("empty", 1'b1, 1'b1);
        accept("empty");
        done("empty", 1'b1);

        // "abc" with latency check
        send(32'h6162_6300, 3'd3, 1'b1);
        chk("abc_lat1", blk_valid, 1'b0);
        tick();
        chk("abc_lat2", blk_valid, 1'b1);
        clr_ew();
        ew[0]  = 32'h6162_6380;
        ew[15] = 32'h0000_0018;
        check_blk("abc", 1'b1, 1'b1);
        accept("abc");
        done("abc", 1'b1);

        // 55 bytes
        for (int i = 0; i < 13; i++) send(32'h1000_0000 + 32'(i), 3'd4, 1'b0);
        send(32'hAABB_CC00, 3'd3, 1'b1);
        wait_blk("b55");
        clr_ew();
        for (int i = 0; i < 13; i++) ew[i] = 32'h1000_0000 + 32'(i);
        ew[13] = 32'hAABB_CC80;
        ew[15] = 32'h0000_01B8;
        check_blk("b55", 1'b1, 1'b1);
        accept("b55");
        done("b55", 1'b1);

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 13; i++) send(32'h2000_0000 + 32'(i), 3'd4, 1'b0);
        send(32'h2000_000D, 3'd4, 1'b1);
        wait_blk("b56a");
        clr_ew();
        for (int i = 0; i < 14; i++) ew[i] = 32'h2000_0000 + 32'(i);
        ew[14] = 32'h8000_0000;
        check_blk("b56a", 1'b1, 1'b0);
        accept("b56a");
        done("b56a", 1'b0);
        wait_blk("b56b");
        clr_ew();
        ew[15] = 32'h0000_01C0;
        check_blk("b56b", 1'b0, 1'b1);
        accept("b56b");
        done("b56b", 1'b1);

        // 64 bytes: marker deferred to the second block
        for (int i = 0; i < 15; i++) send(32'h3000_0000 + 32'(i), 3'd4, 1'b0);
        send(32'h3000_000F, 3'd4, 1'b1);
        chk("b64_lat", blk_valid, 1'b1);
        clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = 32'h3000_0000 + 32'(i);
        check_blk("b64a", 1'b1, 1'b0);
        accept("b64a");
        done("b64a", 1'b0);
        wait_blk("b64b");
        clr_ew();
        ew[0]  = 32'h8000_0000;
        ew[15] = 32'h0000_0200;
        check_blk("b64b", 1'b0, 1'b1);
        accept("b64b");
        done("b64b", 1'b1);

        // Backpressure with a stray core_done, then reset during WAIT
        send(32'h6162_6300, 3'd3, 1'b1);
        wait_blk("bp");
        snap = blk_data;
        for (int i = 0; i < 5; i++) begin
            core_done = (i == 2);
            tick();
            chk("bp_stable", blk_data, snap);
            chk("bp_valid", blk_valid, 1'b1);
            chk("bp_inrdy", in_ready, 1'b0);
        end
        core_done = 1'b0;
        accept("bp");
        rst = 1'b1;
        #1;
        chk("rst2_inrdy", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_valid", blk_valid, 1'b0);
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_data", blk_data, 512'h0);
        send(32'h6162_6300, 3'd3, 1'b1);
        wait_blk("abc2");
        clr_ew();
        ew[0]  = 32'h6162_6380;
        ew[15] = 32'h0000_0018;
        check_blk("abc2", 1'b1, 1'b1);
        accept("abc2");
        done("abc2", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
